// File: rtl/topo_pkg.sv
// Shared types and default sizing for the topological ready-node scheduler.
package topo_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        RUN,
        DONE
    } state_t;

    localparam int unsigned NODE_IDX_W = 10;
    localparam int unsigned COUNTER_W  = 4;
    localparam int unsigned FIFO_DEPTH = 32;
    localparam int unsigned NUM_NODES  = 2 ** NODE_IDX_W;

endpackage

// File: rtl/ready_fifo.sv
// Synchronous FIFO of ready node indices; pushes while full are dropped.
module ready_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_acc;
    logic             pop_acc;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign push_acc = push && !full;
    assign pop_acc  = pop && !empty;
    assign head     = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers are PTR_W bits wide, so DEPTH being a power of two gives free wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_acc) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_acc, pop_acc})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/topo_ready_queue.sv
// Kahn-style scheduler: per-node pending in-degree table feeding a ready FIFO.
module topo_ready_queue
    import topo_pkg::*;
#(
    parameter int unsigned PARAM_NODE_IDX_WIDTH = NODE_IDX_W,
    parameter int unsigned PARAM_COUNTER_WIDTH  = COUNTER_W,
    parameter int unsigned PARAM_FIFO_DEPTH     = FIFO_DEPTH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start_run,
    input  logic                                init_valid,
    input  logic [PARAM_NODE_IDX_WIDTH-1:0]     init_idx,
    input  logic [PARAM_COUNTER_WIDTH-1:0]      init_count,
    input  logic                                load_done,
    input  logic                                dec_valid,
    input  logic [PARAM_NODE_IDX_WIDTH-1:0]     dec_idx,
    output logic                                dec_ready,
    input  logic                                run_finish,
    input  logic                                pop_ready,
    output logic                                pop_valid,
    output logic [PARAM_NODE_IDX_WIDTH-1:0]     next_node_idx,
    output logic [$clog2(PARAM_FIFO_DEPTH):0]   fifo_count,
    output logic                                busy,
    output logic                                done,
    output logic                                err_underflow,
    output logic                                err_overflow
);

    localparam int unsigned IW    = PARAM_NODE_IDX_WIDTH;
    localparam int unsigned CW    = PARAM_COUNTER_WIDTH;
    localparam int unsigned NODES = 2 ** IW;

    state_t          state;
    state_t          state_next;
    logic [IW-1:0]   clr_addr;
    logic            finish_pending;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   count_table [NODES];
    logic [CW-1:0]   dec_cur;
    logic            tbl_we;
    logic [IW-1:0]   tbl_waddr;
    logic [CW-1:0]   tbl_wdata;
    logic            push;
    logic [IW-1:0]   push_idx;
    logic            flush;
    logic            set_underflow;
    logic            set_overflow;

    assign dec_ready = (state == RUN) && !fifo_full;
    assign dec_cur   = count_table[dec_idx];
    assign busy      = (state == CLEAR) || (state == LOAD) || (state == RUN);
    assign done      = (state == DONE);
    assign pop_valid = !fifo_empty;

    // start_run dominates every state, discarding any same-cycle init or decrement.
    always_comb begin
        state_next    = state;
        tbl_we        = 1'b0;
        tbl_waddr     = '0;
        tbl_wdata     = '0;
        push          = 1'b0;
        push_idx      = '0;
        flush         = 1'b0;
        set_underflow = 1'b0;
        set_overflow  = 1'b0;
        if (start_run) begin
            state_next = CLEAR;
            flush      = 1'b1;
        end else begin
            case (state)
                IDLE: ;
                CLEAR: begin
                    tbl_we    = 1'b1;
                    tbl_waddr = clr_addr;
                    if (clr_addr == '1) begin
                        state_next = LOAD;
                    end
                end
                LOAD: begin
                    if (init_valid) begin
                        tbl_we    = 1'b1;
                        tbl_waddr = init_idx;
                        tbl_wdata = init_count;
                        if (init_count == '0) begin
                            push         = 1'b1;
                            push_idx     = init_idx;
                            set_overflow = fifo_full;
                        end
                    end
                    if (load_done) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (dec_valid && dec_ready) begin
                        if (dec_cur == '0) begin
                            set_underflow = 1'b1;
                        end else begin
                            tbl_we    = 1'b1;
                            tbl_waddr = dec_idx;
                            tbl_wdata = dec_cur - CW'(1);
                            if (dec_cur == CW'(1)) begin
                                push     = 1'b1;
                                push_idx = dec_idx;
                            end
                        end
                    end
                    if (finish_pending && fifo_empty) begin
                        state_next = DONE;
                    end
                end
                DONE: ;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_addr       <= '0;
            finish_pending <= 1'b0;
            err_underflow  <= 1'b0;
            err_overflow   <= 1'b0;
        end else if (start_run) begin
            clr_addr       <= '0;
            finish_pending <= 1'b0;
            err_underflow  <= 1'b0;
            err_overflow   <= 1'b0;
        end else begin
            if (state == CLEAR) begin
                clr_addr <= clr_addr + IW'(1);
            end
            if ((state == RUN) && run_finish) begin
                finish_pending <= 1'b1;
            end
            if (set_underflow) begin
                err_underflow <= 1'b1;
            end
            if (set_overflow) begin
                err_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (tbl_we) begin
            count_table[tbl_waddr] <= tbl_wdata;
        end
    end

    ready_fifo #(
        .WIDTH (IW),
        .DEPTH (PARAM_FIFO_DEPTH)
    ) u_ready_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push),
        .push_data (push_idx),
        .pop       (pop_ready),
        .head      (next_node_idx),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_topo_ready_queue.sv
// Self-checking bench for topo_ready_queue against a queue-based Kahn model.
module tb_topo_ready_queue;

    localparam int IW    = 10;
    localparam int CW    = 4;
    localparam int DEPTH = 32;
    localparam int NODES = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_run;
    logic          init_valid;
    logic [IW-1:0] init_idx;
    logic [CW-1:0] init_count;
    logic          load_done;
    logic          dec_valid;
    logic [IW-1:0] dec_idx;
    logic          dec_ready;
    logic          run_finish;
    logic          pop_ready;
    logic          pop_valid;
    logic [IW-1:0] next_node_idx;
    logic [5:0]    fifo_count;
    logic          busy;
    logic          done;
    logic          err_underflow;
    logic          err_overflow;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    topo_ready_queue #(
        .PARAM_NODE_IDX_WIDTH (IW),
        .PARAM_COUNTER_WIDTH  (CW),
        .PARAM_FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_run     (start_run),
        .init_valid    (init_valid),
        .init_idx      (init_idx),
        .init_count    (init_count),
        .load_done     (load_done),
        .dec_valid     (dec_valid),
        .dec_idx       (dec_idx),
        .dec_ready     (dec_ready),
        .run_finish    (run_finish),
        .pop_ready     (pop_ready),
        .pop_valid     (pop_valid),
        .next_node_idx (next_node_idx),
        .fifo_count    (fifo_count),
        .busy          (busy),
        .done          (done),
        .err_underflow (err_underflow),
        .err_overflow  (err_overflow)
    );

    // Reference model: phase, pending counts per node, ready list, sticky flags.
    typedef enum {S_IDLE, S_CLEAR, S_LOAD, S_RUN, S_DONE} mstate_t;
    mstate_t m_state;
    int      m_clr;
    int      m_cnt [NODES];
    int      m_q [$];
    bit      m_unf, m_ovf, m_fin;

    task automatic model_reset();
        m_state = S_IDLE;
        m_q.delete();
        m_unf = 0;
        m_ovf = 0;
        m_fin = 0;
    endtask

    task automatic model_step();
        int sz0    = m_q.size();
        bit fin0   = m_fin;
        bit do_pop = pop_ready && (sz0 > 0);
        if (start_run) begin
            m_state = S_CLEAR;
            m_clr   = 0;
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_q.delete();
            m_unf = 0;
            m_ovf = 0;
            m_fin = 0;
            return;
        end
        if (do_pop) void'(m_q.pop_front());
        case (m_state)
            S_CLEAR: begin
                m_clr++;
                if (m_clr == NODES) m_state = S_LOAD;
            end
            S_LOAD: begin
                if (init_valid) begin
                    m_cnt[init_idx] = int'(init_count);
                    if (init_count == 0) begin
                        if (sz0 == DEPTH) m_ovf = 1;
                        else m_q.push_back(int'(init_idx));
                    end
                end
                if (load_done) m_state = S_RUN;
            end
            S_RUN: begin
                if (dec_valid && sz0 < DEPTH) begin
                    if (m_cnt[dec_idx] == 0) m_unf = 1;
                    else begin
                        m_cnt[dec_idx]--;
                        if (m_cnt[dec_idx] == 0) m_q.push_back(int'(dec_idx));
                    end
                end
                if (run_finish) m_fin = 1;
                if (fin0 && sz0 == 0) m_state = S_DONE;
            end
            default: ;
        endcase
    endtask

    function automatic logic [20:0] exp_obs();
        logic [9:0] h = (m_q.size() > 0) ? 10'(m_q[0]) : 10'd0;
        return {m_q.size() > 0, h, 6'(m_q.size()),
                (m_state == S_CLEAR) || (m_state == S_LOAD) || (m_state == S_RUN),
                m_state == S_DONE, m_unf, m_ovf};
    endfunction

    function automatic logic [20:0] dut_obs();
        return {pop_valid, next_node_idx, fifo_count, busy, done, err_underflow, err_overflow};
    endfunction

    function automatic bit exp_dec_ready();
        return (m_state == S_RUN) && (m_q.size() < DEPTH);
    endfunction

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        start_run  = 0;
        init_valid = 0;
        load_done  = 0;
        dec_valid  = 0;
        run_finish = 0;
        pop_ready  = 0;
    endtask

    task automatic load(input int idx, input int cnt);
        init_valid = 1;
        init_idx   = IW'(idx);
        init_count = CW'(cnt);
        cycle();
    endtask

    task automatic dec(input int idx);
        dec_valid = 1;
        dec_idx   = IW'(idx);
        cycle();
    endtask

    task automatic pop1();
        pop_ready = 1;
        cycle();
    endtask

    // The final CLEAR cycle optionally carries an init that must be ignored.
    task automatic do_start(input bit probe);
        start_run = 1;
        cycle();
        repeat (NODES - 1) cycle();
        if (probe) begin
            init_valid = 1;
            init_idx   = '0;
            init_count = '0;
        end
        cycle();
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (dut_obs() !== 21'd0 || dec_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h/%b expected 0/0", dut_obs(), dec_ready);
        end
        rst = 0;
        model_reset();
    endtask

    task automatic test_chain();
        int got [$];
        do_start(1);
        tests_run++;
        if (fifo_count !== 6'd0 || pop_valid !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL clear_ignores_init: count=%0d valid=%b busy=%b expected 0/0/1", fifo_count, pop_valid, busy);
        end
        load(5, 0);
        tests_run++;
        if (pop_valid !== 1'b1 || next_node_idx !== 10'd5) begin
            tests_failed++;
            $display("FAIL source_push_latency: valid=%b head=%0d expected 1/5", pop_valid, next_node_idx);
        end
        load(7, 1);
        load(9, 2);
        load_done = 1;
        cycle();
        got.push_back(int'(next_node_idx));
        pop1();
        dec(7);
        tests_run++;
        if (pop_valid !== 1'b1 || next_node_idx !== 10'd7) begin
            tests_failed++;
            $display("FAIL dec_push_latency: valid=%b head=%0d expected 1/7", pop_valid, next_node_idx);
        end
        got.push_back(int'(next_node_idx));
        pop1();
        dec(9);
        tests_run++;
        if (pop_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL partial_dec_no_push: valid=%b expected 0", pop_valid);
        end
        dec(9);
        got.push_back(int'(next_node_idx));
        pop1();
        tests_run++;
        if (got.size() != 3 || got[0] != 5 || got[1] != 7 || got[2] != 9) begin
            tests_failed++;
            $display("FAIL chain_order: got %p expected 5 7 9", got);
        end
        tests_run++;
        if (dut_obs() !== exp_obs() || err_underflow !== 1'b0 || err_overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL chain_final: got %h expected %h", dut_obs(), exp_obs());
        end
    endtask

    task automatic test_underflow();
        dec(3);
        tests_run++;
        if (err_underflow !== 1'b1 || fifo_count !== 6'd0) begin
            tests_failed++;
            $display("FAIL underflow: flag=%b count=%0d expected 1/0", err_underflow, fifo_count);
        end
        dec(3);
        tests_run++;
        if (dut_obs() !== exp_obs()) begin
            tests_failed++;
            $display("FAIL underflow_table_unchanged: got %h expected %h", dut_obs(), exp_obs());
        end
    endtask

    task automatic test_overflow();
        do_start(0);
        for (int i = 0; i < 33; i++) begin
            load(300 + i, 0);
            tests_run++;
            if (dut_obs() !== exp_obs()) begin
                tests_failed++;
                $display("FAIL load_overflow[%0d]: got %h expected %h", i, dut_obs(), exp_obs());
            end
        end
        tests_run++;
        if (fifo_count !== 6'd32 || err_overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL overflow_flag: count=%0d flag=%b expected 32/1", fifo_count, err_overflow);
        end
    endtask

    task automatic test_full();
        do_start(0);
        for (int i = 0; i < 32; i++) load(100 + i, 1);
        load(12, 1);
        load(200, 1);
        load_done = 1;
        cycle();
        for (int i = 0; i < 32; i++) begin
            tests_run++;
            if (dec_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL dec_ready_open[%0d]: got %b expected 1", i, dec_ready);
            end
            dec(100 + i);
        end
        tests_run++;
        if (fifo_count !== 6'd32 || dec_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_backpressure: count=%0d ready=%b expected 32/0", fifo_count, dec_ready);
        end
        dec(200);
        tests_run++;
        if (dut_obs() !== exp_obs()) begin
            tests_failed++;
            $display("FAIL dec_while_full: got %h expected %h", dut_obs(), exp_obs());
        end
        pop1();
        tests_run++;
        if (fifo_count !== 6'd31 || dec_ready !== 1'b1 || next_node_idx !== 10'd101) begin
            tests_failed++;
            $display("FAIL pop_reopens: count=%0d ready=%b head=%0d expected 31/1/101", fifo_count, dec_ready, next_node_idx);
        end
    endtask

    task automatic test_simul();
        while (m_q.size() > 4) begin
            pop1();
            tests_run++;
            if (dut_obs() !== exp_obs()) begin
                tests_failed++;
                $display("FAIL drain: got %h expected %h", dut_obs(), exp_obs());
            end
        end
        pop_ready = 1;
        dec_valid = 1;
        dec_idx   = 10'd12;
        cycle();
        tests_run++;
        if (fifo_count !== 6'd4) begin
            tests_failed++;
            $display("FAIL push_pop_count: got %0d expected 4", fifo_count);
        end
        repeat (3) pop1();
        tests_run++;
        if (next_node_idx !== 10'd12 || fifo_count !== 6'd1) begin
            tests_failed++;
            $display("FAIL push_pop_tail: head=%0d count=%0d expected 12/1", next_node_idx, fifo_count);
        end
    endtask

    task automatic test_finish();
        dec(200);
        run_finish = 1;
        cycle();
        tests_run++;
        if (done !== 1'b0 || fifo_count !== 6'd2) begin
            tests_failed++;
            $display("FAIL finish_pending: done=%b count=%0d expected 0/2", done, fifo_count);
        end
        pop1();
        pop1();
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL finish_not_yet: done=%b busy=%b expected 0/1", done, busy);
        end
        cycle();
        tests_run++;
        if (done !== 1'b1 || busy !== 1'b0 || dut_obs() !== exp_obs()) begin
            tests_failed++;
            $display("FAIL finish_done: got %h expected %h", dut_obs(), exp_obs());
        end
    endtask

    task automatic test_restart();
        do_start(0);
        load(20, 0);
        load(21, 0);
        load(22, 0);
        load_done = 1;
        cycle();
        dec(3);
        tests_run++;
        if (fifo_count !== 6'd3 || err_underflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL restart_setup: count=%0d unf=%b expected 3/1", fifo_count, err_underflow);
        end
        start_run = 1;
        dec_valid = 1;
        dec_idx   = 10'd3;
        cycle();
        tests_run++;
        if (busy !== 1'b1 || fifo_count !== 6'd0 || pop_valid !== 1'b0 || err_underflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL restart_flush: busy=%b count=%0d valid=%b unf=%b expected 1/0/0/0", busy, fifo_count, pop_valid, err_underflow);
        end
        repeat (NODES) cycle();
        load(40, 0);
        tests_run++;
        if (pop_valid !== 1'b1 || next_node_idx !== 10'd40) begin
            tests_failed++;
            $display("FAIL reload_after_restart: valid=%b head=%0d expected 1/40", pop_valid, next_node_idx);
        end
        #2 rst = 1;
        #1;
        tests_run++;
        if (dut_obs() !== 21'd0 || dec_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: got %h/%b expected 0/0", dut_obs(), dec_ready);
        end
        @(posedge clk);
        #1 rst = 0;
        model_reset();
    endtask

    task automatic test_random();
        int nodes [24];
        int guard;
        do_start(0);
        foreach (nodes[i]) begin
            nodes[i] = int'($urandom_range(500, 1023));
            load(nodes[i], int'($urandom_range(0, 3)));
        end
        load_done = 1;
        cycle();
        for (int c = 0; c < 400; c++) begin
            tests_run++;
            if (dec_ready !== exp_dec_ready()) begin
                tests_failed++;
                $display("FAIL rand_dec_ready[%0d]: got %b expected %b", c, dec_ready, exp_dec_ready());
            end
            dec_valid = ($urandom_range(0, 9) < 6);
            dec_idx   = ($urandom_range(0, 9) < 9) ? IW'(nodes[$urandom_range(0, 23)]) : IW'($urandom_range(0, 1023));
            pop_ready = ($urandom_range(0, 9) < 4);
            cycle();
            tests_run++;
            if (dut_obs() !== exp_obs()) begin
                tests_failed++;
                $display("FAIL rand_step[%0d]: got %h expected %h", c, dut_obs(), exp_obs());
            end
        end
        run_finish = 1;
        cycle();
        guard = 0;
        while (m_state != S_DONE && guard < 64) begin
            pop1();
            guard++;
        end
        tests_run++;
        if (done !== 1'b1 || dut_obs() !== exp_obs()) begin
            tests_failed++;
            $display("FAIL rand_done: got %h expected %h done=%b", dut_obs(), exp_obs(), done);
        end
    endtask

    initial begin
        start_run  = 0;
        init_valid = 0;
        init_idx   = '0;
        init_count = '0;
        load_done  = 0;
        dec_valid  = 0;
        dec_idx    = '0;
        run_finish = 0;
        pop_ready  = 0;
        model_reset();
        test_reset();
        test_chain();
        test_underflow();
        test_overflow();
        test_full();
        test_simul();
        test_finish();
        test_restart();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1);
    end

endmodule

// File: doc/topo_ready_queue.md
Name: topo_ready_queue

Overview:
- Kahn-style ready-node scheduler that sits directly upstream of digital_top's node walker.
- Holds a pending in-degree counter for every node and accepts "edge resolved" decrement events.
- When a node's counter reaches zero, the node index is pushed into a ready FIFO.
- The walker pops that FIFO to get its next node_idx, so nodes are processed in topological order for path-count accumulation.

Parameters:
- PARAM_NODE_IDX_WIDTH, 10, node index width; the counter table holds 2**W entries.
- PARAM_COUNTER_WIDTH, 4, width of each pending in-degree counter.
- PARAM_FIFO_DEPTH, 32, ready-FIFO entries; must be a power of two.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- start_run  in  1  one-cycle pulse; begins clear/load of a new graph.
- init_valid  in  1  load one node's in-degree (LOAD state only).
- init_idx  in  NODE_IDX_W  node being loaded.
- init_count  in  COUNTER_W  in-degree of init_idx.
- load_done  in  1  pulse; the loader has finished, enter RUN.
- dec_valid  in  1  one incoming edge of dec_idx is resolved.
- dec_idx  in  NODE_IDX_W  target node of the resolved edge.
- dec_ready  out  1  decrement accepted this cycle when dec_valid&dec_ready.
- run_finish  in  1  pulse; no more decrements will be issued.
- pop_ready  in  1  consumer takes the head entry.
- pop_valid  out  1  FIFO non-empty.
- next_node_idx  out  NODE_IDX_W  FIFO head.
- fifo_count  out  clog2(DEPTH)+1  current occupancy.
- busy  out  1  state is CLEAR, LOAD or RUN.
- done  out  1  state is DONE.
- err_underflow  out  1  sticky; a decrement hit a zero counter.
- err_overflow  out  1  sticky; a push was dropped because the FIFO was full.

Behaviour:
- Reset:
  - state=IDLE; FIFO pointers and count are 0.
  - All outputs 0: pop_valid, dec_ready, busy, done, both error flags.
  - next_node_idx=0.
  - The counter table is not reset; it is cleared by the CLEAR state.
- State IDLE:
  - start_run -> CLEAR.
- State CLEAR:
  - Writes 0 to one table entry per cycle, address 0 up to 2**W-1: 1024 cycles at the defaults.
  - Then -> LOAD.
  - FIFO is flushed and error flags are cleared on entry.
- State LOAD:
  - Each init_valid writes table[init_idx]=init_count.
  - If init_count==0, init_idx is pushed to the FIFO in the same cycle (source node).
  - load_done -> RUN.
  - init_valid is ignored in every state other than LOAD.
- State RUN:
  - dec_ready = (state==RUN) && (fifo_count < DEPTH). This is conservative, so a push is always possible.
  - On an accepted decrement: c=table[dec_idx] is read combinationally.
    - If c==0: set err_underflow; the table is unchanged and nothing is pushed.
    - Else: write c-1. If c==1, push dec_idx.
  - Push-to-visible latency is 1 cycle: pop_valid/next_node_idx reflect the push at the next edge.
  - Pop: pop_valid&pop_ready advances the read pointer.
  - Simultaneous push and pop: both occur and fifo_count is unchanged.
  - Pop when the FIFO is empty: no-op.
  - run_finish sets a finish_pending flag.
  - RUN -> DONE at the first cycle with finish_pending=1 and fifo_count==0.
- State DONE:
  - done=1; holds until start_run -> CLEAR.
- Load-phase push when the FIFO is full (more than DEPTH sources): drop the push and set err_overflow.
- start_run in CLEAR, LOAD, RUN or DONE: restart to CLEAR on the next cycle and flush the FIFO. An in-flight decrement in that cycle is discarded.
- Duplicate init of the same idx: last write wins. A second zero-count init of the same idx pushes the node again (loader responsibility).
- FIFO pointers wrap modulo DEPTH; fifo_count ranges 0..DEPTH.
- rst asserted mid-operation: immediately returns to the reset values above.

Decomposition:
- Shared package topo_pkg holds:
  - state enum {IDLE, CLEAR, LOAD, RUN, DONE};
  - default widths NODE_IDX_W=10, COUNTER_W=4, FIFO_DEPTH=32;
  - the derived constant NUM_NODES = 2**NODE_IDX_W.
- One sub-module, ready_fifo: a parameterised synchronous FIFO with push, pop, head, count, full and empty.
- The counter table and FSM stay in topo_ready_queue.

Test Plan:
1. Basic chain:
   - Stimulus: start_run; wait for the 1024-cycle clear. Init node 5 count 0, node 7 count 1, node 9 count 2; load_done. Pop 5, then dec 7, dec 9, dec 9.
   - Response: pop order is 5, 7, 9. Each becomes pop_valid one cycle after its triggering init/dec. No error flags.
2. Underflow:
   - Stimulus: in RUN, dec node 3 (count 0).
   - Response: err_underflow=1 on the next cycle; fifo_count stays 0; table[3] stays 0.
3. FIFO full backpressure:
   - Stimulus: load 32 nodes with count 1; dec all 32 without popping.
   - Response: fifo_count=32 and dec_ready=0. After one pop, dec_ready=1 again and fifo_count=31.
4. Simultaneous push and pop:
   - Stimulus: fifo_count=4; in the same cycle, pop and a dec that zeroes node 12.
   - Response: fifo_count stays 4; 12 appears at the tail.
5. Finish handling:
   - Stimulus: run_finish while fifo_count=2; then pop twice.
   - Response: done=0 until the cycle after the second pop, then done=1 and busy=0.
6. Restart and reset mid-run:
   - Stimulus: start_run during RUN with fifo_count=3.
   - Response: next cycle is CLEAR, fifo_count=0, pop_valid=0, errors cleared.
   - Stimulus: rst asserted in LOAD.
   - Response: asynchronously returns to IDLE with all outputs 0.
